// File: rtl/qed_pkg.sv
// qed_pkg: shared definitions for the SQED instruction-stream constraint.
// Holds RV32I opcode/funct constants, the instruction class codes and the
// sequencer state encoding used by qed_inst_decode and qed_inst_sequencer.
package qed_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  // Sequencer-private padding opcode; all other bits are don't-care.
  localparam logic [6:0] OP_NOP    = 7'b1111111;

  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_R      = 4'd1,
    CLS_I      = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9,
    CLS_FENCE  = 4'd10,
    CLS_SYSTEM = 4'd11,
    CLS_NOP    = 4'd12
  } inst_class_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/qed_inst_decode.sv
// qed_inst_decode: combinational RV32I subset classifier.
// Ports:
//   instruction  in  32  candidate instruction
//   inst_class   out     class code (qed_pkg::inst_class_t)
//   class_legal  out 1   instruction is within the permitted subset
// Register operands must be below REG_LIMIT; loads/stores are confined to a
// small absolute window off x0 bounded by LD_IMM_MAX / ST_IMM7_MAX.
module qed_inst_decode
  import qed_pkg::*;
#(
  parameter int unsigned REG_LIMIT   = 16,
  parameter int unsigned LD_IMM_MAX  = 64,
  parameter int unsigned ST_IMM7_MAX = 2
) (
  input  logic [31:0] instruction,
  output inst_class_t inst_class,
  output logic        class_legal
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [11:0] imm_i;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];
  assign imm_i  = instruction[31:20];

  logic rd_ok, rs1_ok, rs2_ok, rd_zero, rs1_zero, win_ok, ld_imm_ok, st_imm_ok;

  assign rd_ok     = {27'd0, rd}  < REG_LIMIT;
  assign rs1_ok    = {27'd0, rs1} < REG_LIMIT;
  assign rs2_ok    = {27'd0, rs2} < REG_LIMIT;
  assign rd_zero   = (rd == 5'd0);
  assign rs1_zero  = (rs1 == 5'd0);
  assign win_ok    = (instruction[31:30] == 2'b00);
  assign ld_imm_ok = {20'd0, imm_i}  < LD_IMM_MAX;
  assign st_imm_ok = {25'd0, funct7} < ST_IMM7_MAX;

  always_comb begin
    inst_class  = CLS_NONE;
    class_legal = 1'b0;
    case (opcode)
      OP_REG: begin
        inst_class  = CLS_R;
        class_legal = rd_ok && rs1_ok && rs2_ok &&
                      ((funct7 == F7_ZERO) ||
                       ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_IMM: begin
        inst_class = CLS_I;
        // Only the shift-immediates constrain the upper bits.
        if (funct3 == 3'b001)
          class_legal = rd_ok && rs1_ok && (funct7 == F7_ZERO);
        else if (funct3 == 3'b101)
          class_legal = rd_ok && rs1_ok && ((funct7 == F7_ZERO) || (funct7 == F7_ALT));
        else
          class_legal = rd_ok && rs1_ok;
      end
      OP_LOAD: begin
        inst_class  = CLS_LOAD;
        class_legal = rd_ok && rs1_zero && win_ok && ld_imm_ok &&
                      (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OP_STORE: begin
        inst_class  = CLS_STORE;
        class_legal = rs2_ok && rs1_zero && win_ok && st_imm_ok &&
                      (funct3 inside {3'b000, 3'b001, 3'b010});
      end
      OP_BRANCH: begin
        inst_class  = CLS_BRANCH;
        class_legal = rs1_ok && rs2_ok && (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      // PC-dependent results differ between original and duplicate copies,
      // so these classes may only target x0.
      OP_JAL: begin
        inst_class  = CLS_JAL;
        class_legal = rd_zero;
      end
      OP_JALR: begin
        inst_class  = CLS_JALR;
        class_legal = rd_zero && rs1_ok && (funct3 == 3'b000);
      end
      OP_AUIPC: begin
        inst_class  = CLS_AUIPC;
        class_legal = rd_zero;
      end
      OP_LUI: begin
        inst_class  = CLS_LUI;
        class_legal = rd_ok;
      end
      OP_FENCE: begin
        inst_class  = CLS_FENCE;
        class_legal = rd_ok && (funct3 == 3'b000);
      end
      OP_SYSTEM: begin
        inst_class  = CLS_SYSTEM;
        class_legal = (funct3 == 3'b000) && rs1_zero && rd_zero &&
                      ((imm_i == 12'h000) || (imm_i == 12'h001));
      end
      OP_NOP: begin
        inst_class  = CLS_NOP;
        class_legal = 1'b1;
      end
      default: begin
        inst_class  = CLS_NONE;
        class_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/qed_inst_sequencer.sv
// qed_inst_sequencer: stateful SQED instruction-stream constraint.
// Admits MAX_INSTS real instructions from the permitted RV32I subset, then
// only NOPs for DRAIN_CYCLES unstalled cycles, then stays in DONE.
// Ports:
//   clk, reset_n       clock (rising edge), async active-low reset
//   instruction [31:0] candidate instruction
//   inst_valid, stall  issue happens when inst_valid && !stall
//   inst_allowed       combinational legality in the current state
//   inst_class  [3:0]  combinational class code (qed_pkg)
//   issue_count        registered count of accepted real instructions
//   seq_state   [1:0]  registered RUN/DRAIN/DONE
//   qed_done           registered, high in DONE
//   violation          registered, sticky: a disallowed instruction issued
// Macro QED_ASSUME_EN: when defined, inst_allowed is emitted as a formal
// assumption; otherwise the outputs are purely observational.
module qed_inst_sequencer
  import qed_pkg::*;
#(
  parameter int unsigned REG_LIMIT    = 16,
  parameter int unsigned LD_IMM_MAX   = 64,
  parameter int unsigned ST_IMM7_MAX  = 2,
  parameter int unsigned MAX_INSTS    = 32,
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter int          CNT_W        = $clog2(MAX_INSTS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      instruction,
  input  logic             inst_valid,
  input  logic             stall,
  output logic             inst_allowed,
  output logic [3:0]       inst_class,
  output logic [CNT_W-1:0] issue_count,
  output logic [1:0]       seq_state,
  output logic             qed_done,
  output logic             violation
);

  localparam int               DRN_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_INSTS);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES);

  inst_class_t      cls;
  logic             class_legal;
  seq_state_t       state;
  logic [DRN_W-1:0] drain_cnt;
  logic             issue;

  qed_inst_decode #(
    .REG_LIMIT   (REG_LIMIT),
    .LD_IMM_MAX  (LD_IMM_MAX),
    .ST_IMM7_MAX (ST_IMM7_MAX)
  ) u_decode (
    .instruction (instruction),
    .inst_class  (cls),
    .class_legal (class_legal)
  );

  always_comb begin
    inst_allowed = 1'b0;
    if (state == ST_RUN) inst_allowed = class_legal;
    else                 inst_allowed = (cls == CLS_NOP);
  end

  assign inst_class = cls;
  assign seq_state  = state;
  assign issue      = inst_valid && !stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      issue_count <= '0;
      drain_cnt   <= '0;
      qed_done    <= 1'b0;
      violation   <= 1'b0;
    end else begin
      if (issue && !inst_allowed) violation <= 1'b1;
      case (state)
        ST_RUN: begin
          if (issue && inst_allowed && (cls != CLS_NOP)) begin
            issue_count <= issue_count + 1'b1;
            if (issue_count == CNT_LAST - 1'b1) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Drain time is counted in unstalled cycles, valid or not.
          if (!stall) begin
            drain_cnt <= drain_cnt + 1'b1;
            if (drain_cnt == DRN_LAST - 1'b1) begin
              state    <= ST_DONE;
              qed_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef QED_ASSUME_EN
  qed_allowed_a: assume property (@(posedge clk) disable iff (!reset_n) inst_allowed);
`else
  // No assumption: the formal environment or bench consumes inst_allowed.
`endif

endmodule

// File: doc/qed_inst_sequencer.md
# qed_inst_sequencer

Parametrised, stateful instruction-stream constraint for SQED formal runs on the vscale core. It classifies each fetched instruction against the allowed RV32I subset (register-partition and memory-window limits now set by parameters) and bounds the program length: a fixed number of real instructions, then a NOP-only drain, then done. It sits between the symbolic instruction source and the core's fetch port. It drives an `inst_allowed` flag plus a status and violation interface, and can optionally emit the formal assumption itself.

## Interface
- `REG_LIMIT`, 16: architectural registers usable by original instructions; rs1/rs2/rd must be < REG_LIMIT (power of two, 2..32).
- `LD_IMM_MAX`, 64: load imm12 must be < LD_IMM_MAX; loads require rs1 == 0 and instruction[31:30] == 0.
- `ST_IMM7_MAX`, 2: store imm7 must be < ST_IMM7_MAX; stores require rs1 == 0 and instruction[31:30] == 0.
- `MAX_INSTS`, 32: real (non-NOP) instructions accepted before drain (≥1).
- `DRAIN_CYCLES`, 8: NOP-only cycles between end of program and done (≥1).
- `CNT_W`, $clog2(MAX_INSTS+1): issue counter width.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `instruction` in 32: candidate instruction.
- `inst_valid` in 1: instruction presented this cycle.
- `stall` in 1: core not accepting; no issue this cycle.
- `inst_allowed` out 1: combinational; instruction legal in current state.
- `inst_class` out 4: combinational class code (qed_pkg): NONE, R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, SYSTEM, NOP.
- `issue_count` out CNT_W: registered count of accepted real instructions.
- `seq_state` out 2: registered state: RUN, DRAIN, DONE.
- `qed_done` out 1: registered; high in DONE.
- `violation` out 1: registered, sticky; an illegal instruction was issued.

## Operation
- Class legality is per RV32I encoding: funct3/funct7 exact; SRLI/SRAI/SLLI funct7 checked; ECALL/EBREAK with rs1 = rd = 0.
- Always-zero-rd classes (depend on PC): JAL, JALR (also rs1 < REG_LIMIT), AUIPC. LUI/FENCE: rd < REG_LIMIT.
- NOP: opcode 7'b1111111, any other bits.
- Issue = `inst_valid && !stall`.
- RUN: `inst_allowed` = class legal. An issue of a legal non-NOP increments `issue_count`. A NOP issue does not count.
- DRAIN: `inst_allowed` = class is NOP. The drain counter increments every cycle with `!stall`, whether or not `inst_valid` is high.
- DONE: `inst_allowed` = class is NOP; terminal until reset.
- Transitions:
  - RUN→DRAIN: at the edge where an issue of a legal non-NOP brings `issue_count` to MAX_INSTS.
  - DRAIN→DONE: at the edge where the drain counter reaches DRAIN_CYCLES.
- Issue of a disallowed instruction: `violation` is set at the next edge and stays set; the counter is not incremented; the state is unchanged.
- `inst_allowed` ignores `inst_valid` and `stall`.
- `issue_count` never exceeds MAX_INSTS. It holds in DRAIN and DONE.

## Timing
- Classification and `inst_allowed`: zero latency, combinational from `instruction` and `seq_state`.
- Counters, state, `violation`: update on the rising `clk` edge following the issue.
- Reset values: `issue_count` = 0, drain counter = 0, `seq_state` = RUN, `qed_done` = 0, `violation` = 0. Reset is effective immediately, including mid-DRAIN.
- `stall` high: counters, state and the drain counter all freeze. `inst_allowed` still evaluates.
- MAX_INSTS = 1: the first legal issue moves the block directly to DRAIN.

## Configuration
- Macro: `QED_ASSUME_EN`.
- Defined: the block contains `assume property (@(posedge clk) disable iff (!reset_n) inst_allowed)`. The formal tool never sees an illegal instruction, and `violation` stays 0 in proofs.
- Not defined: no assumption is emitted. The outputs are purely observational, for simulation or an external constraint.

## Structure
- `qed_pkg`: opcode/funct constants, `inst_class_t` enum, `seq_state_t` enum, NOP opcode constant.
- Sub-module `qed_inst_decode`: combinational field extraction, class code and per-class legality.
  - Its inputs are `instruction` and the limit parameters.
  - Its outputs are `inst_class` and `class_legal`.
- The top level holds the FSM, the counters and the assumption.

## Test plan
- Reset, then issue ADDI x1,x2,5 (0x00510093) → `inst_allowed` = 1, class I, `issue_count` = 1 next cycle.
- Issue ADDI x17,x2,5 (0x00510893) with REG_LIMIT = 16 → `inst_allowed` = 0; `violation` = 1 next cycle and stays set; `issue_count` unchanged.
- LW x1,4(x0) (0x00402083) → allowed. LW x1,64(x0) (0x04002083) → disallowed.
- MAX_INSTS = 4, DRAIN_CYCLES = 3: 4 legal issues, with NOP 0x0000007F interleaved and uncounted → DRAIN. While in DRAIN, ADDI is disallowed and NOP is allowed. `qed_done` = 1 three unstalled cycles later.
- Hold `stall` = 1 for 5 cycles in DRAIN → drain counter frozen; `qed_done` is delayed by 5 cycles.
- Assert `reset_n` = 0 mid-DRAIN → `seq_state` = RUN, counters = 0, `violation` = 0 immediately, without waiting for a clock edge.
